ub_write_arbiter: RTL and testbench
===================================

// Module: ub_write_arbiter
// PURPOSE
//  Owns the unified-buffer write port; shares it between two requesters.
//  Requester 1: host activation loads (valid/ready). Requester 2: an accumulator writeback
//  sequencer that reads N accumulator rows, requantizes RES->ACT and writes them to the UB.
//  Sits between accumulator.data_o / host side and unified_buffer write_i/addr_wr/in.
// PARAMETERS
//  MUL_SIZE  8   lanes per row (systolic array width)
//  ACT_W     8   activation bits per lane (signed)
//  RES_W     32  accumulator bits per lane (signed)
//  UB_AW     12  unified buffer address bits
//  ACC_AW    7   accumulator address bits
//  SHIFT     8   arithmetic right shift applied before saturation
//  RELU      0   1: clamp negative results to 0 after saturation
// PORTS
//  clk_i          in   1                  clock
//  rst_i          in   1                  async reset, active-high
//  host_valid_i   in   1                  host has a row to write
//  host_ready_o   out  1                  host row accepted this cycle (valid&&ready)
//  host_addr_i    in   UB_AW              host UB row address
//  host_data_i    in   ACT_W x MUL_SIZE   host row (unpacked [MUL_SIZE])
//  wb_start_i     in   1                  start writeback burst (pulse)
//  wb_acc_base_i  in   ACC_AW             first accumulator row
//  wb_ub_base_i   in   UB_AW              first UB row
//  wb_rows_i      in   ACC_AW+1           rows to move (0..128)
//  wb_busy_o      out  1                  burst in progress
//  wb_done_o      out  1                  1-cycle pulse, last row written
//  acc_rd_en_o    out  1                  accumulator read strobe
//  acc_addr_rd_o  out  ACC_AW             accumulator read address
//  acc_data_i     in   RES_W x MUL_SIZE   accumulator row, valid 1 cycle after acc_rd_en_o
//  ub_write_o     out  1                  UB write strobe (registered)
//  ub_addr_wr_o   out  UB_AW              UB write address (registered)
//  ub_data_o      out  ACT_W x MUL_SIZE   UB write row (registered)
// BEHAVIOUR
//  Reset (async): all outputs 0, FSM IDLE, hold FIFO empty, last_grant=WB, no done pulse.
//  FSM: IDLE -wb_start_i-> RUN (rows>0) or DONE (rows==0); RUN -last read issued-> DRAIN;
//   DRAIN -hold FIFO empty and last write granted-> DONE; DONE -> IDLE (wb_done_o=1 here).
//  wb_start_i ignored unless IDLE; base/rows latched on start. wb_busy_o=1 in RUN/DRAIN/DONE.
//  Reads: RUN issues acc_rd_en_o with addr=base+k, k=0..rows-1, addr wraps mod 2^ACC_AW.
//   Credit rule: (reads in flight + FIFO entries - rows granted this cycle) <= 2;
//   2-entry hold FIFO captures acc_data_i 1 cycle after each read; it never overflows.
//  Requantize per lane: v = acc >>> SHIFT; saturate to [-2^(ACT_W-1), 2^(ACT_W-1)-1];
//   RELU=1 -> negative results become 0. Done on FIFO write, so the FIFO stores ACT_W lanes.
//  Arbitration, per cycle: reqH=host_valid_i, reqW=FIFO not empty.
//   Single requester -> granted. Both -> the one NOT in last_grant wins; last_grant updates
//   on every grant. host_ready_o = grant_host (combinational from host_valid_i, 0 in reset).
//  Write: grant at cycle t -> ub_write_o=1 at t+1 with the granted addr/data.
//   WB row k goes to wb_ub_base+k mod 2^UB_AW, strictly in order.
//   Host latency: 1 cycle. WB latency: read t -> FIFO t+1 -> earliest UB write t+2.
//  Uncontested throughput: 1 row/cycle for either requester. ub_addr/data hold their last
//   value when ub_write_o=0.
//  Reset mid-burst: in-flight reads and FIFO contents are discarded; no partial done pulse.
//  Host writes are accepted in every state; no address-overlap checking (software owns it).
// TESTING
//  1 Reset: hold rst_i with random inputs -> all outputs 0; release -> host_ready_o follows valid.
//  2 WB alone: acc rows 0..3 = lanes 256*(r+1), base ub=0x100, rows=4, SHIFT=8 ->
//    acc_rd_en 4 consecutive cycles, ub writes 0x100..0x103 with data 1..4, first write at
//    start+3, wb_done_o one cycle after last write.
//  3 Contention: host_valid_i held high during a 4-row WB -> grants alternate H,W,H,W...
//    (host first after reset), no WB row lost or reordered, done after 4 WB writes.
//  4 Saturation: acc lanes {0x7FFF_FFFF, 0x8000_0000, 0x0000_7F00, 0xFFFF_FF00} SHIFT=8 ->
//    {127, -128, 127, -1}; RELU=1 -> {127, 0, 127, 0}.
//  5 Edges: rows=0 -> no reads/writes, wb_done_o 2 cycles after start; acc base 126,
//    rows=4 -> reads 126,127,0,1; wb_start_i pulsed while busy -> ignored.
//  6 Reset asserted at the second WB write -> outputs 0 immediately; after release no
//    stale writes and no wb_done_o; a new start runs clean.

Source files
------------

// File: rtl/ub_write_arbiter.sv
// Unified-buffer write port arbiter: host activation rows vs. accumulator
// writeback bursts (requantized RES_W -> ACT_W), round-robin on contention.
module ub_write_arbiter #(
  parameter int MUL_SIZE = 8,
  parameter int ACT_W    = 8,
  parameter int RES_W    = 32,
  parameter int UB_AW    = 12,
  parameter int ACC_AW   = 7,
  parameter int SHIFT    = 8,
  parameter int RELU     = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    host_valid_i,
  output logic                    host_ready_o,
  input  logic [UB_AW-1:0]        host_addr_i,
  input  logic signed [ACT_W-1:0] host_data_i [MUL_SIZE],
  input  logic                    wb_start_i,
  input  logic [ACC_AW-1:0]       wb_acc_base_i,
  input  logic [UB_AW-1:0]        wb_ub_base_i,
  input  logic [ACC_AW:0]         wb_rows_i,
  output logic                    wb_busy_o,
  output logic                    wb_done_o,
  output logic                    acc_rd_en_o,
  output logic [ACC_AW-1:0]       acc_addr_rd_o,
  input  logic signed [RES_W-1:0] acc_data_i [MUL_SIZE],
  output logic                    ub_write_o,
  output logic [UB_AW-1:0]        ub_addr_wr_o,
  output logic signed [ACT_W-1:0] ub_data_o [MUL_SIZE]
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef logic [MUL_SIZE-1:0][ACT_W-1:0] row_t;

  localparam logic LG_WB   = 1'b0;
  localparam logic LG_HOST = 1'b1;
  localparam logic [ACC_AW:0] ONE_R = (ACC_AW+1)'(1);
  localparam logic signed [RES_W-1:0] AMAX =
    RES_W'((2 ** (ACT_W - 1)) - 1);
  localparam logic signed [RES_W-1:0] AMIN = ~AMAX;

  state_t            state_q, state_d;
  logic [ACC_AW-1:0] rd_addr_q, rd_addr_d;
  logic [ACC_AW:0]   rd_left_q, rd_left_d;
  logic [ACC_AW:0]   gnt_left_q, gnt_left_d;
  logic [UB_AW-1:0]  wb_addr_q, wb_addr_d;
  logic              rdv_q, rdv_d;
  row_t              fifo_q [2];
  row_t              fifo_d [2];
  logic              rptr_q, rptr_d;
  logic              wptr_q, wptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              ub_we_q, ub_we_d;
  logic [UB_AW-1:0]  ub_addr_q, ub_addr_d;
  row_t              ub_data_q, ub_data_d;
  logic              done_q, done_d;

  row_t       host_row, acc_row, head_row;
  logic       req_h, req_w, gnt_h, gnt_w;
  logic       rd_en, push, pop;
  logic [2:0] occ;

  function automatic logic [ACT_W-1:0] requant(
    input logic signed [RES_W-1:0] a
  );
    logic signed [RES_W-1:0] v;
    v = a >>> SHIFT;
    if (v > AMAX) v = AMAX;
    else if (v < AMIN) v = AMIN;
    if (RELU != 0 && v[RES_W-1]) v = '0;
    return v[ACT_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < MUL_SIZE; i++) begin
      host_row[i] = host_data_i[i];
      acc_row[i]  = requant(acc_data_i[i]);
    end
  end

  // Arriving accumulator data may be granted in the cycle it lands
  always_comb begin
    req_h    = host_valid_i && !rst_i;
    req_w    = (cnt_q != 2'd0) || rdv_q;
    gnt_h    = req_h && (!req_w || last_q == LG_WB);
    gnt_w    = req_w && (!req_h || last_q == LG_HOST);
    head_row = (cnt_q != 2'd0) ? fifo_q[rptr_q] : acc_row;
    pop      = gnt_w && (cnt_q != 2'd0);
    push     = rdv_q && !(gnt_w && cnt_q == 2'd0);
    occ      = {1'b0, cnt_q} + {2'b0, rdv_q} - {2'b0, gnt_w};
    rd_en    = (state_q == S_RUN) && (occ <= 3'd1);
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_left_d  = rd_left_q;
    gnt_left_d = gnt_left_q;
    wb_addr_d  = wb_addr_q;
    rdv_d      = rd_en;
    done_d     = (state_q == S_DONE);
    if (gnt_w) begin
      gnt_left_d = gnt_left_q - ONE_R;
      wb_addr_d  = wb_addr_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (wb_start_i) begin
          rd_addr_d  = wb_acc_base_i;
          rd_left_d  = wb_rows_i;
          gnt_left_d = wb_rows_i;
          wb_addr_d  = wb_ub_base_i;
          state_d    = (wb_rows_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          rd_addr_d = rd_addr_q + 1'b1;
          rd_left_d = rd_left_q - ONE_R;
          if (rd_left_q == ONE_R) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (gnt_w && gnt_left_q == ONE_R) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = acc_row;
    wptr_d    = wptr_q ^ push;
    rptr_d    = rptr_q ^ pop;
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    last_d    = last_q;
    ub_we_d   = gnt_h || gnt_w;
    ub_addr_d = ub_addr_q;
    ub_data_d = ub_data_q;
    if (gnt_h) begin
      last_d    = LG_HOST;
      ub_addr_d = host_addr_i;
      ub_data_d = host_row;
    end else if (gnt_w) begin
      last_d    = LG_WB;
      ub_addr_d = wb_addr_q;
      ub_data_d = head_row;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rd_addr_q  <= '0;
      rd_left_q  <= '0;
      gnt_left_q <= '0;
      wb_addr_q  <= '0;
      rdv_q      <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
      cnt_q      <= '0;
      last_q     <= LG_WB;
      ub_we_q    <= 1'b0;
      ub_addr_q  <= '0;
      ub_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_left_q  <= rd_left_d;
      gnt_left_q <= gnt_left_d;
      wb_addr_q  <= wb_addr_d;
      rdv_q      <= rdv_d;
      fifo_q     <= fifo_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ub_we_q    <= ub_we_d;
      ub_addr_q  <= ub_addr_d;
      ub_data_q  <= ub_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    host_ready_o  = gnt_h;
    acc_rd_en_o   = rd_en;
    acc_addr_rd_o = rd_addr_q;
    wb_busy_o     = (state_q != S_IDLE);
    wb_done_o     = done_q;
    ub_write_o    = ub_we_q;
    ub_addr_wr_o  = ub_addr_q;
    for (int i = 0; i < MUL_SIZE; i++) begin
      ub_data_o[i] = ub_data_q[i];
    end
  end

endmodule

// File: tb/tb_ub_write_arbiter.sv
// Directed bench for ub_write_arbiter: reset, writeback, contention,
// requantization, edge cases and mid-burst reset.
module tb_ub_write_arbiter;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic              host_valid_i, host_ready_o;
  logic [11:0]       host_addr_i;
  logic signed [7:0] host_data_i [8];
  logic              wb_start_i;
  logic [6:0]        wb_acc_base_i;
  logic [11:0]       wb_ub_base_i;
  logic [7:0]        wb_rows_i;
  logic              wb_busy_o, wb_done_o, acc_rd_en_o;
  logic [6:0]        acc_addr_rd_o;
  logic signed [31:0] acc_data_i [8];
  logic              ub_write_o;
  logic [11:0]       ub_addr_wr_o;
  logic signed [7:0] ub_data_o [8];

  logic              r_host_ready, r_busy, r_done, r_rd_en, r_ub_write;
  logic [6:0]        r_acc_addr;
  logic [11:0]       r_ub_addr;
  logic signed [7:0] r_ub_data [8];

  ub_write_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .host_addr_i(host_addr_i), .host_data_i(host_data_i),
    .wb_start_i(wb_start_i), .wb_acc_base_i(wb_acc_base_i),
    .wb_ub_base_i(wb_ub_base_i), .wb_rows_i(wb_rows_i),
    .wb_busy_o(wb_busy_o), .wb_done_o(wb_done_o),
    .acc_rd_en_o(acc_rd_en_o), .acc_addr_rd_o(acc_addr_rd_o),
    .acc_data_i(acc_data_i), .ub_write_o(ub_write_o),
    .ub_addr_wr_o(ub_addr_wr_o), .ub_data_o(ub_data_o)
  );

  ub_write_arbiter #(.RELU(1)) u_relu (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_valid_i(host_valid_i), .host_ready_o(r_host_ready),
    .host_addr_i(host_addr_i), .host_data_i(host_data_i),
    .wb_start_i(wb_start_i), .wb_acc_base_i(wb_acc_base_i),
    .wb_ub_base_i(wb_ub_base_i), .wb_rows_i(wb_rows_i),
    .wb_busy_o(r_busy), .wb_done_o(r_done),
    .acc_rd_en_o(r_rd_en), .acc_addr_rd_o(r_acc_addr),
    .acc_data_i(acc_data_i), .ub_write_o(r_ub_write),
    .ub_addr_wr_o(r_ub_addr), .ub_data_o(r_ub_data)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int s;
  int h;
  logic signed [31:0] mem [128][8];

  logic [11:0] wa [$];
  logic [63:0] wd [$];
  int          wc [$];
  logic [6:0]  ra [$];
  int          rc [$];
  int          dc [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  // synchronous-read accumulator model
  always @(posedge clk_i)
    if (acc_rd_en_o)
      for (int i = 0; i < 8; i++) acc_data_i[i] <= mem[acc_addr_rd_o][i];

  function automatic logic [63:0] pk(input logic signed [7:0] d [8]);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = d[i];
    return r;
  endfunction

  function automatic logic [63:0] rep(input logic [7:0] b);
    return {8{b}};
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (ub_write_o) begin
        wa.push_back(ub_addr_wr_o);
        wd.push_back(pk(ub_data_o));
        wc.push_back(cyc);
      end
      if (acc_rd_en_o) begin
        ra.push_back(acc_addr_rd_o);
        rc.push_back(cyc);
      end
      if (wb_done_o) dc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
    ra.delete(); rc.delete(); dc.delete();
  endtask

  task automatic set_host(input logic [7:0] b);
    for (int i = 0; i < 8; i++) host_data_i[i] = b;
  endtask

  task automatic kick(input logic [6:0] ab, input logic [11:0] ub,
                      input logic [7:0] n);
    tick();
    wb_start_i = 1'b1;
    wb_acc_base_i = ab;
    wb_ub_base_i = ub;
    wb_rows_i = n;
    s = cyc;
    tick();
    wb_start_i = 1'b0;
  endtask

  logic [11:0] c3_addr [9];
  logic [7:0]  c3_data [9];
  logic        c3_hr [9];

  initial begin
    c3_addr = '{12'h800, 12'h801, 12'h100, 12'h802, 12'h101,
                12'h803, 12'h102, 12'h804, 12'h103};
    c3_data = '{8'h40, 8'h41, 8'h01, 8'h42, 8'h02,
                8'h43, 8'h03, 8'h44, 8'h04};
    c3_hr   = '{1, 1, 0, 1, 0, 1, 0, 1, 0};
    for (int r = 0; r < 128; r++)
      for (int i = 0; i < 8; i++) mem[r][i] = '0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) mem[r][i] = 32'(256 * (r + 1));
    for (int i = 0; i < 8; i++) begin
      mem[126][i] = 32'(256 * 5);
      mem[127][i] = 32'(256 * 6);
    end
    mem[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_7F00,
                32'hFFFF_FF00, 32'h0000_0100, 32'hFFFF_8000,
                32'h1234_5678, 32'hFFFF_FFFF};
    for (int i = 0; i < 8; i++) acc_data_i[i] = '0;
    rst_i = 1'b1;
    host_valid_i = 0; host_addr_i = '0; set_host(8'h00);
    wb_start_i = 0; wb_acc_base_i = '0; wb_ub_base_i = '0; wb_rows_i = '0;

    // reset with random inputs
    for (int k = 0; k < 3; k++) begin
      tick();
      host_valid_i = 1'($urandom_range(0, 1));
      host_addr_i = 12'($urandom);
      set_host(8'($urandom));
      wb_start_i = 1'($urandom_range(0, 1));
      wb_acc_base_i = 7'($urandom);
      wb_ub_base_i = 12'($urandom);
      wb_rows_i = 8'($urandom);
      @(negedge clk_i);
      chk("rst_ctrl", {ub_write_o, ub_addr_wr_o, host_ready_o, acc_rd_en_o,
                       acc_addr_rd_o, wb_busy_o, wb_done_o}, 64'd0);
      chk("rst_data", pk(ub_data_o), 64'd0);
    end
    tick();
    wb_start_i = 0; wb_rows_i = '0; wb_acc_base_i = '0; wb_ub_base_i = '0;
    host_valid_i = 1; host_addr_i = 12'h7; set_host(8'h00);
    rst_i = 0;
    @(negedge clk_i);
    chk("rel_hready1", host_ready_o, 1);
    tick();
    host_valid_i = 0;
    @(negedge clk_i);
    chk("rel_hready0", host_ready_o, 0);

    // writeback alone
    tick();
    clr();
    kick(7'd0, 12'h100, 8'd4);
    repeat (10) tick();
    chk("wb_nreads", ra.size(), 4);
    chk("wb_rd_first", rc[0], s + 1);
    chk("wb_rd_last", rc[3], s + 4);
    chk("wb_rd_addr3", ra[3], 7'd3);
    chk("wb_nwrites", wa.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("wb_addr", wa[k], 12'h100 + 12'(k));
      chk("wb_data", wd[k], rep(8'(k + 1)));
      chk("wb_wcyc", wc[k], s + 3 + k);
    end
    chk("wb_ndone", dc.size(), 1);
    chk("wb_done_cyc", dc[0], s + 7);
    chk("wb_busy_end", wb_busy_o, 0);

    // contention after a fresh reset
    rst_i = 1;
    tick();
    rst_i = 0;
    tick();
    clr();
    h = 0;
    wb_start_i = 1; wb_acc_base_i = 7'd0; wb_ub_base_i = 12'h100;
    wb_rows_i = 8'd4; host_valid_i = 1;
    s = cyc;
    for (int k = 0; k < 9; k++) begin
      host_addr_i = 12'h800 + 12'(h);
      set_host(8'h40 + 8'(h));
      @(negedge clk_i);
      chk("c3_hready", host_ready_o, c3_hr[k]);
      if (host_ready_o) h++;
      tick();
      wb_start_i = 0;
    end
    host_valid_i = 0;
    repeat (6) tick();
    chk("c3_nwrites", wa.size(), 9);
    for (int k = 0; k < 9; k++) begin
      chk("c3_addr", wa[k], c3_addr[k]);
      chk("c3_data", wd[k], rep(c3_data[k]));
      chk("c3_wcyc", wc[k], s + 1 + k);
    end
    chk("c3_ndone", dc.size(), 1);
    chk("c3_done_cyc", dc[0], s + 10);

    // requantization and saturation
    clr();
    kick(7'd10, 12'h200, 8'd1);
    tick();
    tick();
    @(negedge clk_i);
    chk("sat_we", ub_write_o, 1);
    chk("sat_addr", ub_addr_wr_o, 12'h200);
    chk("sat_data", pk(ub_data_o), 64'hFF7F_8001_FF7F_807F);
    chk("relu_we", r_ub_write, 1);
    chk("relu_data", pk(r_ub_data), 64'h007F_0001_007F_007F);
    repeat (5) tick();

    // zero-row burst
    clr();
    kick(7'd5, 12'h300, 8'd0);
    repeat (6) tick();
    chk("z_nreads", ra.size(), 0);
    chk("z_nwrites", wa.size(), 0);
    chk("z_ndone", dc.size(), 1);
    chk("z_done_cyc", dc[0], s + 2);

    // accumulator address wrap plus ignored start while busy
    clr();
    kick(7'd126, 12'hFFE, 8'd4);
    tick();
    wb_start_i = 1; wb_acc_base_i = 7'd50; wb_ub_base_i = 12'h300;
    wb_rows_i = 8'd2;
    tick();
    wb_start_i = 0;
    repeat (10) tick();
    chk("wr_nreads", ra.size(), 4);
    chk("wr_rd0", ra[0], 7'd126);
    chk("wr_rd1", ra[1], 7'd127);
    chk("wr_rd2", ra[2], 7'd0);
    chk("wr_rd3", ra[3], 7'd1);
    chk("wr_nwrites", wa.size(), 4);
    chk("wr_addr2", wa[2], 12'h000);
    chk("wr_data0", wd[0], rep(8'd5));
    chk("wr_data2", wd[2], rep(8'd1));
    chk("wr_ndone", dc.size(), 1);

    // reset at the second writeback write
    clr();
    kick(7'd0, 12'h100, 8'd4);
    tick();
    tick();
    tick();
    chk("mr_we2", ub_write_o, 1);
    chk("mr_addr2", ub_addr_wr_o, 12'h101);
    rst_i = 1;
    #1;
    chk("mr_rst_outs", {ub_write_o, ub_addr_wr_o, wb_busy_o, wb_done_o,
                        acc_rd_en_o, acc_addr_rd_o}, 64'd0);
    tick();
    rst_i = 0;
    clr();
    repeat (10) tick();
    chk("mr_stale_w", wa.size(), 0);
    chk("mr_stale_d", dc.size(), 0);
    kick(7'd2, 12'h050, 8'd2);
    repeat (8) tick();
    chk("mr_nwrites", wa.size(), 2);
    chk("mr_addr0", wa[0], 12'h050);
    chk("mr_data0", wd[0], rep(8'd3));
    chk("mr_addr1", wa[1], 12'h051);
    chk("mr_data1", wd[1], rep(8'd4));
    chk("mr_ndone", dc.size(), 1);
    chk("mr_done_cyc", dc[0], s + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
